// File: rtl/fir_pkg.sv
// Shared constants, state encoding and default coefficients for the time-multiplexed FIR.
package fir_pkg;

    localparam int unsigned DEF_TAPS = 4;
    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_CW   = 8;
    localparam int unsigned DEF_OW   = 16;
    localparam int unsigned DEF_KW   = $clog2(DEF_TAPS);
    localparam int unsigned ACCW     = DEF_DW + DEF_CW + DEF_KW;

    localparam longint OUT_MAX = (longint'(1) << (DEF_OW - 1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) << (DEF_OW - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Reset value of coefficient k.
    function automatic int default_coef(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate with clear/enable and a saturated view of the running sum.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned AW      = ACCW,
    parameter int unsigned OW      = DEF_OW,
    parameter longint      SAT_MAX = OUT_MAX,
    parameter longint      SAT_MIN = OUT_MIN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] x,
    input  logic signed [CW-1:0] h,
    output logic signed [OW-1:0] sat_c
);

    localparam logic signed [AW-1:0] ACC_MAX = AW'(SAT_MAX);
    localparam logic signed [AW-1:0] ACC_MIN = AW'(SAT_MIN);

    logic signed [DW+CW-1:0] prod_c;
    logic signed [AW-1:0]    sum_c;
    logic signed [AW-1:0]    acc;

    assign prod_c = x * h;
    assign sum_c  = acc + AW'(prod_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

    // Saturation covers the sum including the current term, so the last MAC cycle can capture it directly.
    always_comb begin
        sat_c = OW'(sum_c);
        if (sum_c > ACC_MAX) begin
            sat_c = OW'(ACC_MAX);
        end else if (sum_c < ACC_MIN) begin
            sat_c = OW'(ACC_MIN);
        end
    end

endmodule

// File: rtl/fir_mac_sched.sv
// FIR controller: sequences one shared MAC over TAPS taps per sample, with valid/ready on both sides.
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int unsigned TAPS = DEF_TAPS,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned CW   = DEF_CW,
    parameter int unsigned OW   = DEF_OW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DW-1:0]       s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [OW-1:0]       m_data,
    input  logic                       cfg_we,
    input  logic [$clog2(TAPS)-1:0]    cfg_addr,
    input  logic signed [CW-1:0]       cfg_data,
    output logic                       cfg_err,
    output logic                       busy
);

    localparam int unsigned KW      = $clog2(TAPS);
    localparam int unsigned AW      = DW + CW + KW;
    localparam longint      SAT_MAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint      SAT_MIN = -(longint'(1) << (OW - 1));

    state_t                state;
    logic signed [DW-1:0]  hist [TAPS];
    logic signed [CW-1:0]  coef [TAPS];
    logic [KW-1:0]         k;

    logic                  accept_c;
    logic                  addr_ok_c;
    logic                  cfg_ok_c;
    logic                  last_c;
    logic                  mac_en_c;
    logic signed [OW-1:0]  sat_c;

    generate
        if ((1 << KW) == TAPS) begin : g_pow2
            assign addr_ok_c = 1'b1;
        end else begin : g_npow2
            assign addr_ok_c = (32'(cfg_addr) < TAPS);
        end
    endgenerate

    // s_ready is high only in IDLE, so an accept implies the controller is idle.
    assign accept_c = s_valid && s_ready;
    assign cfg_ok_c = cfg_we && (state == IDLE) && !accept_c && addr_ok_c;
    assign last_c   = (k == KW'(TAPS - 1));
    assign mac_en_c = (state == MAC);

    fir_mac_unit #(
        .DW      (DW),
        .CW      (CW),
        .AW      (AW),
        .OW      (OW),
        .SAT_MAX (SAT_MAX),
        .SAT_MIN (SAT_MIN)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_c),
        .en    (mac_en_c),
        .x     (hist[k]),
        .h     (coef[k]),
        .sat_c (sat_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            cfg_err <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) begin
                hist[i] <= '0;
                coef[i] <= CW'(default_coef(i));
            end
        end else begin
            cfg_err <= cfg_we && !cfg_ok_c;
            if (cfg_ok_c) begin
                coef[cfg_addr] <= cfg_data;
            end

            case (state)
                IDLE: begin
                    if (accept_c) begin
                        for (int i = int'(TAPS) - 1; i > 0; i--) begin
                            hist[i] <= hist[i-1];
                        end
                        hist[0] <= s_data;
                        k       <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    k <= k + KW'(1);
                    if (last_c) begin
                        k       <= '0;
                        m_data  <= sat_c;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed self-checking bench for fir_mac_sched with hand-computed expected results.
module tb_fir_mac_sched;

    logic               clk;
    logic               rst_n;
    logic               s_valid;
    logic               s_ready;
    logic signed [7:0]  s_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] m_data;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic signed [7:0]  cfg_data;
    logic               cfg_err;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;

    fir_mac_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample while idle; returns #1 after the accepting edge.
    task automatic send(input logic signed [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Wait (bounded) for m_valid, check edge count and value, consume if m_ready is high.
    task automatic get(input string tag, input int exp_val, input int exp_lat);
        int n = 0;
        while (m_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_data"}, m_data, exp_val);
        if (m_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [1:0] a, input logic signed [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk("cfg_ok_err", cfg_err, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        #12;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse with default coefficients 1,2,3,4
        send(8'sd1);
        chk("imp_busy", busy, 1);
        chk("imp_s_ready", s_ready, 0);
        get("imp0", 1, 4);
        send(8'sd0); get("imp1", 2, 4);
        send(8'sd0); get("imp2", 3, 4);
        send(8'sd0); get("imp3", 4, 4);
        send(8'sd0); get("imp4", 0, 4);

        // Backpressure: result held while m_ready is low
        m_ready = 1'b0;
        send(8'sd10);
        get("bp", 10, 4);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, 10);
            chk("bp_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_m_valid", m_valid, 0);
        chk("bp_rel_s_ready", s_ready, 1);

        // Positive saturation: history starts 10,0,0,0
        for (int i = 0; i < 4; i++) cfg(2'(i), -8'sd128);
        send(-8'sd128); get("satp0", 15104, 4);
        send(-8'sd128); get("satp1", 31488, 4);
        send(-8'sd128); get("satp2", 32767, 4);
        send(-8'sd128); get("satp3", 32767, 4);

        // Negative saturation: history is all -128
        for (int i = 0; i < 4; i++) cfg(2'(i), 8'sd127);
        for (int i = 0; i < 4; i++) begin
            send(-8'sd128);
            get("satn", -32768, 4);
        end

        // Restore defaults and flush history
        for (int i = 0; i < 4; i++) cfg(2'(i), 8'(i + 1));
        send(8'sd0); get("flush0", -1152, 4);
        send(8'sd0); get("flush1", -896, 4);
        send(8'sd0); get("flush2", -512, 4);
        send(8'sd0); get("flush3", 0, 4);

        // Write during MAC is rejected
        send(8'sd1);
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 8'sd50;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk("cfg_busy_err", cfg_err, 1);
        @(posedge clk);
        #1;
        chk("cfg_busy_err_clr", cfg_err, 0);
        get("cfgb0", 1, 2);
        send(8'sd0); get("cfgb1", 2, 4);
        send(8'sd0); get("cfgb2", 3, 4);
        send(8'sd0); get("cfgb3", 4, 4);

        // Write colliding with an accept: sample wins, coefficient unchanged
        s_valid  = 1'b1;
        s_data   = 8'sd1;
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 8'sd99;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        chk("coll_err", cfg_err, 1);
        chk("coll_busy", busy, 1);
        get("coll", 1, 4);
        send(8'sd0); get("coll1", 2, 4);
        send(8'sd0); get("coll2", 3, 4);
        send(8'sd0); get("coll3", 4, 4);

        // Steady state with constant 127
        send(8'sd127); get("ss0", 127, 4);
        send(8'sd127); get("ss1", 381, 4);
        send(8'sd127); get("ss2", 762, 4);
        send(8'sd127); get("ss3", 1270, 4);
        send(8'sd127); get("ss4", 1270, 4);

        // Async reset during the second MAC cycle
        send(8'sd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_s_ready", s_ready, 1);
        chk("mrst_busy", busy, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'sd1); get("post0", 1, 4);
        send(8'sd0); get("post1", 2, 4);
        send(8'sd0); get("post2", 3, 4);
        send(8'sd0); get("post3", 4, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
